seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit seven-segment scanner with double-buffered frame data.
// Each digit is lit for SCAN_CNT clocks, separated by BLANK_CNT dark clocks.
//
// state    | meaning
// ST_BLANK | all anodes off between digits (anti-ghosting gap)
// ST_SHOW  | current digit index driven with its nibble and decimal point
module seg_scan_driver #(
  parameter int SCAN_CNT  = 100000,
  parameter int BLANK_CNT = 1000
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp,
  input  logic        load,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic        frame_done
);

  localparam int CNT_MAX = (SCAN_CNT > BLANK_CNT) ? SCAN_CNT : BLANK_CNT;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_CNT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CNT - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_idx;

  logic [31:0] r_sh_data;
  logic [7:0]  r_sh_en;
  logic [7:0]  r_sh_dp;
  logic        r_pending;
  logic [31:0] r_disp_data;
  logic [7:0]  r_disp_en;
  logic [7:0]  r_disp_dp;

  logic        r_wrap_d;
  logic        w_show_end;
  logic        w_wrap;
  logic [3:0]  w_nib;
  logic [6:0]  w_dec;
  logic [7:0]  w_an_nxt;
  logic [7:0]  w_seg_nxt;

  assign w_show_end = (r_state == ST_SHOW) && (r_cnt == SCAN_LAST);
  assign w_wrap     = w_show_end && (r_idx == 3'd7);

  // State register
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_state <= ST_BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK: if (r_cnt == BLANK_LAST) w_state_nxt = ST_SHOW;
      ST_SHOW:  if (r_cnt == SCAN_LAST)  w_state_nxt = ST_BLANK;
      default:  w_state_nxt = ST_BLANK;
    endcase
  end

  // Counter clears on every state change, so it never exceeds CNT_MAX-1
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else begin
      if (w_state_nxt != r_state) r_cnt <= '0;
      else                        r_cnt <= r_cnt + CW'(1);
      if (w_show_end) r_idx <= r_idx + 3'd1;
    end
  end

  // Shadow/display sets; display only changes at the frame boundary
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_sh_data   <= '0;
      r_sh_en     <= '0;
      r_sh_dp     <= '0;
      r_pending   <= 1'b0;
      r_disp_data <= '0;
      r_disp_en   <= '0;
      r_disp_dp   <= '0;
    end else begin
      if (load) begin
        r_sh_data <= data;
        r_sh_en   <= digit_en;
        r_sh_dp   <= dp;
      end
      if (w_wrap) begin
        if (load) begin
          r_disp_data <= data;
          r_disp_en   <= digit_en;
          r_disp_dp   <= dp;
        end else if (r_pending) begin
          r_disp_data <= r_sh_data;
          r_disp_en   <= r_sh_en;
          r_disp_dp   <= r_sh_dp;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_nib = r_disp_data[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_dec = 7'h7F;
    case (w_nib)
      4'h0: w_dec = 7'h40;
      4'h1: w_dec = 7'h79;
      4'h2: w_dec = 7'h24;
      4'h3: w_dec = 7'h30;
      4'h4: w_dec = 7'h19;
      4'h5: w_dec = 7'h12;
      4'h6: w_dec = 7'h02;
      4'h7: w_dec = 7'h78;
      4'h8: w_dec = 7'h00;
      4'h9: w_dec = 7'h10;
      4'hA: w_dec = 7'h08;
      4'hB: w_dec = 7'h03;
      4'hC: w_dec = 7'h46;
      4'hD: w_dec = 7'h21;
      4'hE: w_dec = 7'h06;
      4'hF: w_dec = 7'h0E;
      default: w_dec = 7'h7F;
    endcase
  end

  // Output logic
  always_comb begin
    w_an_nxt  = 8'hFF;
    w_seg_nxt = 8'hFF;
    if (r_state == ST_SHOW) begin
      w_an_nxt[r_idx] = ~r_disp_en[r_idx];
      w_seg_nxt       = {~r_disp_dp[r_idx], w_dec};
    end
  end

  // frame_done is delayed twice so it lines up with the registered blank output
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      AN         <= 8'hFF;
      SEG        <= 8'hFF;
      r_wrap_d   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      AN         <= w_an_nxt;
      SEG        <= w_seg_nxt;
      r_wrap_d   <= w_wrap;
      frame_done <= r_wrap_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with SCAN_CNT=4, BLANK_CNT=2 (48-clock frame).
// Stimulus pushes expected lit digits; a negedge monitor pops them as digits light up.
module tb_seg_scan_driver;

  logic        clk_100MHz = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp = '0;
  logic        load = 1'b0;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic        frame_done;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run_len = 0;
  int   last_fd = 0;
  bit   fd_valid = 1'b0;
  logic [7:0] prev_an = 8'hFF;

  seg_scan_driver #(.SCAN_CNT(4), .BLANK_CNT(2)) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .data       (data),
    .digit_en   (digit_en),
    .dp         (dp),
    .load       (load),
    .AN         (AN),
    .SEG        (SEG),
    .frame_done (frame_done)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic push_exp(input logic [7:0] an, input logic [7:0] seg);
    exp_t e;
    e.an  = an;
    e.seg = seg;
    exp_q.push_back(e);
  endtask

  // segs byte i = expected SEG of digit i, all digits enabled
  task automatic push8(input logic [63:0] segs);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] an;
      an    = 8'hFF;
      an[i] = 1'b0;
      push_exp(an, segs[i*8 +: 8]);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got no pulse in %0d cycles, expected one within 48", n);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] p);
    data     = d;
    digit_en = en;
    dp       = p;
    load     = 1'b1;
    @(negedge clk_100MHz);
    load     = 1'b0;
  endtask

  // Monitor: each new lit digit pops one expectation; each pulse checks frame timing
  always @(negedge clk_100MHz) begin
    exp_t e;
    cyc++;
    if (rst) fd_valid = 1'b0;
    if (AN != 8'hFF && prev_an == 8'hFF) begin
      run_len = 1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_digit: got AN=%h SEG=%h, expected dark", AN, SEG);
      end else begin
        e = exp_q.pop_front();
        if (AN !== e.an || SEG !== e.seg) begin
          errors++;
          $display("FAIL digit: got AN=%h SEG=%h, expected AN=%h SEG=%h", AN, SEG, e.an, e.seg);
        end
      end
    end else if (AN != 8'hFF) begin
      run_len++;
    end else if (prev_an != 8'hFF) begin
      checks++;
      if (run_len != 4) begin
        errors++;
        $display("FAIL show_length: got %0d clocks, expected 4", run_len);
      end
    end
    if (frame_done) begin
      checks++;
      if (AN !== 8'hFF || SEG !== 8'hFF || (prev_an != 8'hFF && prev_an != 8'h7F)) begin
        errors++;
        $display("FAIL frame_done_align: got AN=%h SEG=%h prevAN=%h, expected FF FF after digit 7",
                 AN, SEG, prev_an);
      end
      if (fd_valid) begin
        checks++;
        if (cyc - last_fd != 48) begin
          errors++;
          $display("FAIL frame_period: got %0d clocks, expected 48", cyc - last_fd);
        end
      end
      fd_valid = 1'b1;
      last_fd  = cyc;
    end
    prev_an = AN;
  end

  initial begin
    repeat (3) @(negedge clk_100MHz);
    check("reset_AN", 32'(AN), 32'hFF);
    check("reset_SEG", 32'(SEG), 32'hFF);
    check("reset_frame_done", 32'(frame_done), 32'h0);

    // Load right after release: frame 1 stays dark, frame 2 shows 76543210
    rst = 1'b0;
    push8(64'hF882_9299_B0A4_F9C0);
    do_load(32'h7654_3210, 8'hFF, 8'h00);

    // Load mid digit 3 of frame 2: frame 2 keeps old data, frame 3 shows all F
    wait_fd();
    repeat (19) @(negedge clk_100MHz);
    push8({8{8'h8E}});
    do_load(32'hFFFF_FFFF, 8'hFF, 8'h00);

    // Load coincident with the digit-7 SHOW->BLANK edge ending frame 3
    wait_fd();
    repeat (46) @(negedge clk_100MHz);
    push8(64'h8090_8883_C6A1_868E);
    do_load(32'h89AB_CDEF, 8'hFF, 8'h00);
    check("pending_after_same_cycle_load", 32'(dut.r_pending), 32'h0);

    // Sparse enable with one decimal point, shown in frames 5 and 6
    wait_fd();
    push_exp(8'hFE, 8'hF9);
    push_exp(8'hFB, 8'h30);
    push_exp(8'hFE, 8'hF9);
    push_exp(8'hFB, 8'h30);
    do_load(32'h0000_0321, 8'h05, 8'h04);
    wait_fd();
    wait_fd();

    // Pending load followed by reset during SHOW of digit 5: the load never shows
    do_load(32'hFFFF_FFFF, 8'hFF, 8'h00);
    repeat (30) @(negedge clk_100MHz);
    rst = 1'b1;
    @(negedge clk_100MHz);
    rst = 1'b0;
    check("midshow_reset_AN", 32'(AN), 32'hFF);
    check("midshow_reset_SEG", 32'(SEG), 32'hFF);
    check("midshow_reset_pending", 32'(dut.r_pending), 32'h0);
    wait_fd();
    wait_fd();
    wait_fd();
    repeat (4) @(negedge clk_100MHz);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
